// File: rtl/serial_shift_out_driver.sv
// rtl/serial_shift_out_driver.sv - parametrised serial shift-out driver with latch pulse and auto-refresh
//
// Ports:
//   i_CLK    system clock, all logic on the rising edge
//   i_RESET  synchronous active-high reset
//   i_Data   parallel word to send (WIDTH bits)
//   i_Valid  i_Data is valid; accepted when o_Ready is high
//   o_Ready  high in IDLE, a word can be accepted
//   o_SCLK   serial shift clock to the chain
//   o_SData  serial data, stable across each o_SCLK rising edge
//   o_Latch  storage-register latch pulse, LATCH_LEN cycles
//   o_Done   one-cycle pulse in the last latch cycle of every frame

module serial_shift_out_driver #(
  parameter int WIDTH        = 16,
  parameter int DIV          = 2,
  parameter int LATCH_LEN    = 2,
  parameter int MSB_FIRST    = 1,
  parameter int INVERT       = 0,
  parameter int AUTO_REFRESH = 0
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Valid,
  output logic             o_Ready,
  output logic             o_SCLK,
  output logic             o_SData,
  output logic             o_Latch,
  output logic             o_Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW = (LATCH_LEN > 1) ? $clog2(LATCH_LEN) : 1;

  localparam logic [CW-1:0] BITS_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] BITS_ONE  = CW'(1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_LEN - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             armed_q, armed_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [LW-1:0]    lat_cnt_q, lat_cnt_d;

  logic             ready_q, sclk_q, sdata_q, latch_q, done_q;

  logic [WIDTH-1:0] word_in;
  logic             accept;
  logic             refresh;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign word_in = (INVERT != 0) ? ~i_Data : i_Data;
  // ready_q gates acceptance so the cycle right after reset release never accepts.
  assign accept  = (state_q == IDLE) && ready_q && i_Valid;
  assign refresh = (state_q == IDLE) && ready_q && (AUTO_REFRESH != 0) && armed_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    armed_d   = armed_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      IDLE: begin
        // A newly offered word takes priority over a refresh.
        if (accept) begin
          shift_d   = word_in;
          last_d    = word_in;
          armed_d   = 1'b1;
          bit_cnt_d = BITS_INIT;
          div_cnt_d = '0;
          state_d   = SHIFT_LO;
        end else if (refresh) begin
          shift_d   = last_q;
          bit_cnt_d = BITS_INIT;
          div_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          shift_d   = shift_one(shift_q);
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (bit_cnt_q == BITS_ONE) begin
            lat_cnt_d = '0;
            state_d   = LATCH;
          end else begin
            state_d   = SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      last_q    <= '0;
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      lat_cnt_q <= '0;
      ready_q   <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      armed_q   <= armed_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      ready_q   <= (state_d == IDLE);
      sclk_q    <= (state_d == SHIFT_HI);
      sdata_q   <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? head_bit(shift_d) : 1'b0;
      latch_q   <= (state_d == LATCH);
      done_q    <= (state_d == LATCH) && (lat_cnt_d == LAT_LAST);
    end
  end

  assign o_Ready = ready_q;
  assign o_SCLK  = sclk_q;
  assign o_SData = sdata_q;
  assign o_Latch = latch_q;
  assign o_Done  = done_q;

endmodule
